lipsi_uart_loader: RTL and testbench

Upstream stage of lipsi_processor. Receives a program image over a UART serial line and writes it byte-by-byte into the processor's 256-entry instruction memory. Holds the processor in reset while loading, then releases it so execution starts at pc 0. Replaces the hard-coded initial program with a field-loadable one.

---
 rtl/lipsi_uart_loader.sv | 243 ++++++++++++++++++++++++
 tb/tb_lipsi_uart_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/lipsi_uart_loader.sv
// lipsi_uart_loader
// Receives a program image over a UART line and writes it byte by byte into
// the 256-entry instruction memory of lipsi_processor, holding the processor
// in reset while a frame is being loaded.
//
// Frame: SYNC_BYTE, N (0 means 256), N payload bytes[, checksum byte]
//
// Build option: define LIPSI_LOADER_CHECKSUM_EN to expect a trailing checksum
// byte (sum of payload mod 256); a mismatch aborts the frame. Without it the
// frame completes right after the Nth payload byte.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   rx         UART receive line (idle high, asynchronous)
//   wr_en      one-cycle instruction-memory write strobe
//   wr_addr    write address
//   wr_data    write data
//   cpu_hold   high holds the processor in reset
//   load_done  set after a valid frame, cleared by the next SYNC_BYTE
//   load_err   set after an aborted frame, cleared by the next SYNC_BYTE
//   byte_count payload bytes written in the current/last frame (saturates)
module lipsi_uart_loader #(
  parameter int         CLK_FREQ  = 100000000,
  parameter int         BAUD      = 115200,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       cpu_hold,
  output logic       load_done,
  output logic       load_err,
  output logic [7:0] byte_count
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rstate_e;
  typedef enum logic [2:0] {F_IDLE, F_LEN, F_DATA, F_CSUM, F_DONE, F_ERR} fstate_e;

  // Two-flop synchronizer; rx_s3_q is the previous synced value for edge detect.
  logic rx_s1_q, rx_s2_q, rx_s3_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  // ---------------- RX FSM ----------------
  rstate_e       rstate_q, rstate_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sr_q, sr_d;
  logic          byte_valid, frame_err;

  always_comb begin
    rstate_d   = rstate_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    sr_d       = sr_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rstate_q)
      R_IDLE: if (!rx_s2_q && rx_s3_q) begin
        rstate_d = R_START;
        cnt_d    = HALF;
      end
      R_START: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else if (!rx_s2_q) begin
          rstate_d = R_DATA;
          cnt_d    = FULL;
          bit_d    = 3'd0;
        end else rstate_d = R_IDLE;  // glitch shorter than half a bit
      end
      R_DATA: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else begin
          sr_d  = {rx_s2_q, sr_q[7:1]};  // LSB first
          cnt_d = FULL;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) rstate_d = R_STOP;
        end
      end
      R_STOP: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else begin
          if (rx_s2_q) byte_valid = 1'b1;
          else         frame_err  = 1'b1;
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rstate_q <= R_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      sr_q     <= '0;
    end else begin
      rstate_q <= rstate_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sr_q     <= sr_d;
    end
  end

  // ---------------- Frame FSM ----------------
  fstate_e    fstate_q, fstate_d;
  logic [8:0] rem_q, rem_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d, byte_count_q, byte_count_d;
  logic       cpu_hold_q, cpu_hold_d, load_done_q, load_done_d, load_err_q, load_err_d;
`ifdef LIPSI_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif

  always_comb begin
    fstate_d     = fstate_q;
    rem_d        = rem_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    byte_count_d = byte_count_q;
    cpu_hold_d   = cpu_hold_q;
    load_done_d  = load_done_q;
    load_err_d   = load_err_q;
`ifdef LIPSI_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    // Index advances the cycle after the strobe so wr_addr is stable during it;
    // 8-bit wrap only happens for N=256.
    if (wr_en_q) begin
      wr_addr_d = wr_addr_q + 8'd1;
      if (byte_count_q != 8'hFF) byte_count_d = byte_count_q + 8'd1;
    end
    case (fstate_q)
      F_IDLE: if (byte_valid && sr_q == SYNC_BYTE) begin
        fstate_d     = F_LEN;
        cpu_hold_d   = 1'b1;
        load_done_d  = 1'b0;
        load_err_d   = 1'b0;
        byte_count_d = 8'd0;
        wr_addr_d    = 8'd0;
`ifdef LIPSI_LOADER_CHECKSUM_EN
        csum_d       = 8'd0;
`endif
      end
      F_LEN: begin
        if (frame_err) fstate_d = F_ERR;
        else if (byte_valid) begin
          rem_d    = (sr_q == 8'd0) ? 9'd256 : {1'b0, sr_q};
          fstate_d = F_DATA;
        end
      end
      F_DATA: begin
        if (frame_err) fstate_d = F_ERR;
        else if (byte_valid) begin
          wr_en_d   = 1'b1;
          wr_data_d = sr_q;
          rem_d     = rem_q - 9'd1;
`ifdef LIPSI_LOADER_CHECKSUM_EN
          csum_d    = csum_q + sr_q;
          if (rem_q == 9'd1) fstate_d = F_CSUM;
`else
          if (rem_q == 9'd1) fstate_d = F_DONE;
`endif
        end
      end
`ifdef LIPSI_LOADER_CHECKSUM_EN
      F_CSUM: begin
        if (frame_err) fstate_d = F_ERR;
        else if (byte_valid) fstate_d = (sr_q == csum_q) ? F_DONE : F_ERR;
      end
`endif
      F_DONE: begin
        load_done_d = 1'b1;
        cpu_hold_d  = 1'b0;
        fstate_d    = F_IDLE;
      end
      F_ERR: begin
        load_err_d = 1'b1;  // cpu_hold stays set: never run a partial image
        fstate_d   = F_IDLE;
      end
      default: fstate_d = F_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fstate_q     <= F_IDLE;
      rem_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      byte_count_q <= '0;
      cpu_hold_q   <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
`ifdef LIPSI_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      fstate_q     <= fstate_d;
      rem_q        <= rem_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      byte_count_q <= byte_count_d;
      cpu_hold_q   <= cpu_hold_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
`ifdef LIPSI_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cpu_hold   = cpu_hold_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_lipsi_uart_loader.sv
// Testbench for lipsi_uart_loader (DIV = 16). Frames are built from byte
// lists; expected writes and status flags are derived from the frame rules.
module tb_lipsi_uart_loader;

  logic       clk = 1'b0, reset = 1'b0, rx = 1'b1;
  logic       wr_en, cpu_hold, load_done, load_err;
  logic [7:0] wr_addr, wr_data, byte_count;

  lipsi_uart_loader #(.CLK_FREQ(16), .BAUD(1), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .rx(rx), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .cpu_hold(cpu_hold), .load_done(load_done),
    .load_err(load_err), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  // Write monitor: every sampled wr_en cycle becomes one recorded write.
  logic [15:0] wq[$];
  time         wt[$];
  time         pst[$];        // start time of each payload byte sent
  time         done_t = 0;
  logic        done_prev = 1'b0;
  logic [7:0]  pay[$];
  time         last_start;

  always @(negedge clk) begin
    if (wr_en) begin
      wq.push_back({wr_addr, wr_data});
      wt.push_back($time);
    end
    if (load_done && !done_prev) done_t = $time;
    done_prev = load_done;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk); rx = 1'b0; last_start = $time;
    repeat (15) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); rx = b[i];
      repeat (15) @(negedge clk);
    end
    @(negedge clk); rx = stop;
    repeat (15) @(negedge clk);
    if (!stop) begin
      @(negedge clk); rx = 1'b1;
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic clear_mon();
    wq.delete(); wt.delete(); pst.delete(); done_t = 0;
  endtask

  // Sends SYNC, N, pay[], (checksum). bad_stop >= 0 gives that payload byte a
  // low stop bit and ends the frame there. csum_force >= 0 overrides the checksum.
  task automatic run_frame(input string nm, input int bad_stop, input int csum_force);
    int n, exp_n;
    logic [7:0] sum;
    logic err;
    n = pay.size();
    sum = 8'd0;
    foreach (pay[i]) sum = sum + pay[i];
    clear_mon();
    send_byte(8'hA5, 1'b1);
    send_byte(n[7:0], 1'b1);
    chk({nm, ":hold_in_frame"}, {cpu_hold, load_done, load_err}, 3'b100);
    exp_n = n;
    for (int i = 0; i < n; i++) begin
      if (i == bad_stop) begin
        send_byte(pay[i], 1'b0);
        exp_n = i;
        break;
      end
      send_byte(pay[i], 1'b1);
      pst.push_back(last_start);
    end
    err = (bad_stop >= 0);
`ifdef LIPSI_LOADER_CHECKSUM_EN
    if (bad_stop < 0) begin
      if (csum_force >= 0) begin
        send_byte(csum_force[7:0], 1'b1);
        err = (csum_force[7:0] != sum);
      end else send_byte(sum, 1'b1);
    end
`endif
    repeat (8) @(negedge clk);
    chk({nm, ":wr_count"}, wq.size(), exp_n);
    for (int i = 0; i < exp_n && i < wq.size(); i++) begin
      chk($sformatf("%s:addr%0d", nm, i), wq[i][15:8], i[7:0]);
      chk($sformatf("%s:data%0d", nm, i), wq[i][7:0], pay[i]);
      // write lands during the stop bit of its byte (mid-bit sample + 1 clock)
      chk($sformatf("%s:lat%0d", nm, i),
          ((wt[i] - pst[i]) >= 144*10) && ((wt[i] - pst[i]) < 160*10), 1);
    end
    chk({nm, ":load_done"}, load_done, !err);
    chk({nm, ":load_err"}, load_err, err);
    chk({nm, ":cpu_hold"}, cpu_hold, err);
    chk({nm, ":byte_count"}, byte_count, (exp_n > 255) ? 255 : exp_n);
`ifndef LIPSI_LOADER_CHECKSUM_EN
    if (!err && wt.size() > 0) chk({nm, ":done_lat"}, (done_t - wt[wt.size()-1]) / 10, 1);
`endif
  endtask

  initial begin
    // reset
    repeat (3) @(negedge clk);
    chk("rst_in", {wr_en, wr_addr, wr_data, cpu_hold, load_done, load_err, byte_count}, '0);
    reset = 1'b1;
    repeat (500) @(negedge clk);
    chk("idle_writes", wq.size(), 0);
    chk("idle_outs", {wr_en, wr_addr, wr_data, cpu_hold, load_done, load_err, byte_count}, '0);

    // directed frame C7,0A,FF
    pay = '{8'hC7, 8'h0A, 8'hFF};
    run_frame("f1", -1, -1);

`ifdef LIPSI_LOADER_CHECKSUM_EN
    run_frame("bad_csum", -1, 0);
    run_frame("recover1", -1, -1);
`endif

    // short low glitch in idle: no byte, no status change
    clear_mon();
    @(negedge clk); rx = 1'b0;
    repeat (4) @(negedge clk); rx = 1'b1;
    repeat (60) @(negedge clk);
    chk("glitch_writes", wq.size(), 0);
    chk("glitch_status", {load_done, load_err, cpu_hold}, 3'b100);

    // stop bit low on second payload byte
    pay = '{8'hB1, 8'hB2, 8'hB3};
    run_frame("ferr", 1, -1);
    pay = '{8'h5C, 8'h7E};
    run_frame("recover2", -1, -1);

    // SYNC value inside the payload is just data
    pay = '{8'hA5, 8'h00, 8'hA5};
    run_frame("sync_in_data", -1, -1);

    // reset during second payload byte
    clear_mon();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'hC7, 1'b1);
    @(negedge clk); rx = 1'b0;
    repeat (40) @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("rst_mid", {wr_en, wr_addr, wr_data, cpu_hold, load_done, load_err, byte_count}, '0);
    chk("rst_mid_writes", wq.size(), 1);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("rst_after_writes", wq.size(), 1);
    pay = '{8'h12};
    run_frame("post_rst", -1, -1);

    // randomized frames
    for (int f = 0; f < 5; f++) begin
      int n;
      int cf;
      n = $urandom_range(1, 8);
      pay.delete();
      for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
      cf = -1;
`ifdef LIPSI_LOADER_CHECKSUM_EN
      if ($urandom_range(0, 2) == 0) cf = $urandom_range(0, 255);
`endif
      run_frame($sformatf("rnd%0d", f), ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1, cf);
    end

    // N = 0 means 256 bytes: full address range, byte_count saturates
    pay.delete();
    for (int i = 0; i < 256; i++) pay.push_back(8'($urandom));
    run_frame("n256", -1, -1);
    chk("n256_addr_wrap", wr_addr, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case a wait never returns.
  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
